// File: rtl/me_result_collector.sv
`default_nettype none
// ============================================================================
// me_result_collector : serial SAD/MV result lines -> {blk,mvx,mvy,sad} records
//                       queued in a first-word-fall-through FIFO (valid/ready)
// Revision 1.0
// ============================================================================
module me_result_collector #(
   parameter int SAD_W      = 14,
   parameter int MV_W       = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int BLK_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sad_out,
   input  logic                        x_out,
   input  logic                        y_out,
   output logic                        rec_valid,
   input  logic                        rec_ready,
   output logic [SAD_W-1:0]            rec_sad,
   output logic [MV_W-1:0]             rec_mvx,
   output logic [MV_W-1:0]             rec_mvy,
   output logic [BLK_W-1:0]            rec_blk,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        clr_ovf
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int CNT_W = $clog2(SAD_W + 1);
   localparam int REC_W = BLK_W + 2 * MV_W + SAD_W;

   localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] SAD_LAST = CNT_W'(SAD_W - 1);
   localparam logic [CNT_W-1:0] MV_LIM   = CNT_W'(MV_W);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_d;

   logic             start;
   logic             shift_en;
   logic             commit;

   logic [CNT_W-1:0] bit_cnt_q;
   logic [CNT_W-1:0] bit_cnt_d;
   logic [SAD_W-1:0] sad_sr_q;
   logic [SAD_W-1:0] sad_sr_d;
   logic [MV_W-1:0]  x_sr_q;
   logic [MV_W-1:0]  x_sr_d;
   logic [MV_W-1:0]  y_sr_q;
   logic [MV_W-1:0]  y_sr_d;
   logic [BLK_W-1:0] blk_cnt_q;
   logic [BLK_W-1:0] blk_cnt_d;

   logic [REC_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [CW-1:0]    remain;
   logic [REC_W-1:0] head_q;
   logic [REC_W-1:0] head_d;
   logic             rec_valid_q;
   logic             rec_valid_d;
   logic             ovf_q;
   logic             ovf_d;

   logic             pop;
   logic             full;
   logic             push;
   logic             drop;
   logic [REC_W-1:0] push_rec;

   // ------------------------------------------------------------------------
   // Deserialiser FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (sad_out) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_cnt_q == SAD_LAST) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // A high line during COMMIT is the next record's start bit
            state_d = sad_out ? S_SHIFT : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      start    = 1'b0;
      shift_en = 1'b0;
      commit   = 1'b0;
      case (state_q)
         S_IDLE: begin
            start = sad_out;
         end
         S_SHIFT: begin
            shift_en = 1'b1;
         end
         S_COMMIT: begin
            commit = 1'b1;
            start  = sad_out;
         end
         default: begin
            start = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Shift registers and block counter
   // ------------------------------------------------------------------------
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      sad_sr_d  = sad_sr_q;
      x_sr_d    = x_sr_q;
      y_sr_d    = y_sr_q;
      blk_cnt_d = blk_cnt_q;
      if (start) begin
         bit_cnt_d = '0;
      end
      if (shift_en) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
         sad_sr_d  = {sad_sr_q[SAD_W-2:0], sad_out};
         if (bit_cnt_q < MV_LIM) begin
            x_sr_d = {x_sr_q[MV_W-2:0], x_out};
            y_sr_d = {y_sr_q[MV_W-2:0], y_out};
         end
      end
      // Dropped records still consume an index so gaps are visible downstream
      if (commit) begin
         blk_cnt_d = blk_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q <= '0;
         sad_sr_q  <= '0;
         x_sr_q    <= '0;
         y_sr_q    <= '0;
         blk_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         sad_sr_q  <= sad_sr_d;
         x_sr_q    <= x_sr_d;
         y_sr_q    <= y_sr_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Record FIFO with registered head
   // ------------------------------------------------------------------------
   assign pop      = rec_valid_q & rec_ready;
   assign full     = (count_q == DEPTH_C);
   assign push     = commit & (~full | pop);
   assign drop     = commit & full & ~pop;
   assign push_rec = {blk_cnt_q, x_sr_q, y_sr_q, sad_sr_q};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Entries left behind the current head; zero means the new head is the
   // record being pushed this cycle, which is not yet in memory.
   assign remain = count_q - {{(CW-1){1'b0}}, pop};

   always_comb begin
      head_d      = head_q;
      rec_valid_d = (count_d != '0);
      if ((push | pop) && (count_d != '0)) begin
         head_d = (remain == '0) ? push_rec : mem_q[rd_ptr_d];
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_rec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         head_q      <= '0;
         rec_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         head_q      <= head_d;
         rec_valid_q <= rec_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign rec_valid                            = rec_valid_q;
   assign {rec_blk, rec_mvx, rec_mvy, rec_sad} = head_q;
   assign fifo_count                           = count_q;
   assign overflow                             = ovf_q;

endmodule
`default_nettype wire
